flash_loader: RTL and testbench

- Upstream feeder for the core's instruction/data memory flash port: accepts a framed byte stream (e.g. from a UART receiver) and issues one-cycle word writes on flash_addr/flash_data/flash_en.
- Replaces testbench-driven flashing for on-board bring-up. Holds the core in reset while a frame is in progress.

---
 rtl/common.sv | 18 +
 rtl/flash_loader.sv | 134 +++++++++++++
 tb/tb_flash_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/common.sv
// Shared types and constants for the flash loader.
package common;

  typedef enum logic [3:0] {
    IDLE,
    ADDR0,
    ADDR1,
    CNT0,
    CNT1,
    DATA,
    WRITE,
    CSUM,
    ERR
  } loader_state_t;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

endpackage

// File: rtl/flash_loader.sv
// Framed byte stream to word writes on the core flash port.
// Holds the core in reset while a frame is in progress.
module flash_loader
  import common::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             flash_en,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);

  loader_state_t state, next;

  logic [15:0] base;
  logic [15:0] cnt;
  logic [15:0] idx;
  logic [1:0]  bcnt;
  logic [31:0] word;
  logic [7:0]  csum;
  logic [31:0] tcnt;
  logic        acc;
  logic        expired;

  assign rx_ready = (state != WRITE) && (state != ERR);
  assign acc      = rx_valid && rx_ready;
  assign cpu_rst  = rst | busy;

  // WRITE drops ready, so acc is never set there and idle time keeps counting
  assign expired = (state != IDLE) && (state != ERR) && !acc &&
                   (tcnt >= 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:  if (acc && rx_data == LOADER_SYNC) next = ADDR0;
      ADDR0: if (acc) next = ADDR1;
      ADDR1: if (acc) next = CNT0;
      CNT0:  if (acc) next = CNT1;
      CNT1: begin
        if (acc) begin
          if (base[1:0] != 2'b00)          next = ERR;
          else if ({rx_data, cnt[7:0]} == 16'd0) next = CSUM;
          else                              next = DATA;
        end
      end
      DATA:  if (acc && bcnt == 2'd3) next = WRITE;
      WRITE: next = (idx < cnt) ? DATA : CSUM;
      CSUM:  if (acc) next = IDLE;
      ERR:   next = IDLE;
      default: next = IDLE;
    endcase
    if (expired) next = ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base       <= '0;
      cnt        <= '0;
      idx        <= '0;
      bcnt       <= '0;
      word       <= '0;
      csum       <= '0;
      tcnt       <= '0;
      flash_en   <= 1'b0;
      flash_addr <= '0;
      flash_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      flash_en <= 1'b0;
      if (state == IDLE || acc) tcnt <= '0;
      else                      tcnt <= tcnt + 32'd1;
      unique case (state)
        IDLE: begin
          if (acc && rx_data == LOADER_SYNC) begin
            busy <= 1'b1;
            done <= 1'b0;
            err  <= 1'b0;
            csum <= '0;
            idx  <= '0;
            bcnt <= '0;
          end
        end
        ADDR0: if (acc) base[7:0]  <= rx_data;
        ADDR1: if (acc) base[15:8] <= rx_data;
        CNT0:  if (acc) cnt[7:0]   <= rx_data;
        CNT1:  if (acc) cnt[15:8]  <= rx_data;
        DATA: begin
          if (acc) begin
            csum <= csum ^ rx_data;
            word <= {rx_data, word[31:8]};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              flash_en   <= 1'b1;
              flash_data <= WIDTH'({rx_data, word[31:8]});
              flash_addr <= WIDTH'({16'd0, base}) +
                            WIDTH'({14'd0, idx, 2'b00});
              idx        <= idx + 16'd1;
            end
          end
        end
        CSUM: begin
          if (acc) begin
            busy <= 1'b0;
            done <= (rx_data == csum);
            err  <= (rx_data != csum);
          end
        end
        ERR:   busy <= 1'b0;
        default: ;
      endcase
      // Errors become visible while ERR is occupied, busy drops after it
      if (next == ERR && state != ERR) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// Randomized scoreboard bench for flash_loader.
// Expected writes and frame outcomes come from a byte-level frame model.
module tb_flash_loader;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] flash_addr;
  logic [31:0] flash_data;
  logic        flash_en;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  flash_loader #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .flash_addr(flash_addr), .flash_data(flash_data),
    .flash_en(flash_en), .cpu_rst(cpu_rst),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int          total = 0;
  int          bad = 0;
  wr_t         wexp[$];
  logic [1:0]  oexp[$];
  logic [31:0] wq[$];
  logic        busy_d = 1'b0;
  wr_t         we;
  logic [1:0]  oe;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes or ends a frame
  always @(negedge clk) begin
    chk("cpu_rst", 64'(cpu_rst), 64'(rst | busy));
    if (flash_en === 1'b1) begin
      chk("rdy_in_write", 64'(rx_ready), 64'd0);
      if (wexp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h want none",
                 flash_addr, flash_data);
      end else begin
        we = wexp.pop_front();
        chk("w_addr", 64'(flash_addr), 64'(we.a));
        chk("w_data", 64'(flash_data), 64'(we.d));
      end
    end
    if (busy_d && !busy) begin
      if (oexp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_end: got done %0b err %0b want none",
                 done, err);
      end else begin
        oe = oexp.pop_front();
        chk("outcome", 64'({done, err}), 64'(oe));
      end
    end
    busy_d = busy;
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (k == 8) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got rx_ready 0 want 1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // stall/rst_at: number of data bytes sent before stall or reset (-1 none)
  task automatic send_frame(input logic [15:0] base,
                            input int n,
                            input logic bad_cs,
                            input int stall,
                            input int rst_at);
    logic [7:0]  bytes[$];
    logic [31:0] words[$];
    logic [7:0]  cs;
    int          lim;
    int          cut;
    cs = 8'h00;
    for (int i = 0; i < n; i++)
      words.push_back((wq.size() == n) ? wq[i] : $urandom);
    wq.delete();
    bytes.push_back(8'hA5);
    bytes.push_back(base[7:0]);
    bytes.push_back(base[15:8]);
    bytes.push_back(8'(n));
    bytes.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) begin
        bytes.push_back(8'(words[i] >> (8 * j)));
        cs = cs ^ 8'(words[i] >> (8 * j));
      end
    bytes.push_back(bad_cs ? (cs ^ 8'h01) : cs);
    cut = (stall >= 0) ? stall : rst_at;
    lim = bytes.size();
    if (base[1:0] != 2'b00) begin
      lim = 5;
      oexp.push_back(2'b01);
    end else begin
      if (cut >= 0) lim = 5 + cut;
      for (int i = 0; i < n; i++)
        if (cut < 0 || 4 * (i + 1) <= cut)
          wexp.push_back({32'(base) + 32'(4 * i), words[i]});
      if (stall >= 0)       oexp.push_back(2'b01);
      else if (rst_at >= 0) oexp.push_back(2'b00);
      else                  oexp.push_back(bad_cs ? 2'b01 : 2'b10);
    end
    for (int i = 0; i < lim; i++) send_byte(bytes[i]);
    if (stall >= 0) repeat (TO + 4) @(negedge clk);
    if (rst_at >= 0) begin
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_en", 64'(flash_en), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_flags", 64'({done, err}), 64'd0);
      chk("mid_rst_addr", 64'(flash_addr), 64'd0);
      chk("mid_rst_data", 64'(flash_data), 64'd0);
      chk("mid_rst_rdy", 64'(rx_ready), 64'd1);
      rst = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [15:0] b;
    repeat (3) @(negedge clk);
    chk("rst_en", 64'(flash_en), 64'd0);
    chk("rst_rdy", 64'(rx_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flags", 64'({done, err}), 64'd0);
    chk("rst_addr", 64'(flash_addr), 64'd0);
    chk("rst_data", 64'(flash_data), 64'd0);
    chk("rst_cpu", 64'(cpu_rst), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("run_cpu", 64'(cpu_rst), 64'd0);

    wq = '{32'h02802783, 32'h02802803};
    send_frame(16'h0000, 2, 1'b0, -1, -1);
    send_byte(8'h11);
    send_byte(8'h22);
    wq = '{32'h00000001};
    send_frame(16'h0028, 1, 1'b0, -1, -1);
    wq = '{32'h00000001};
    send_frame(16'h0028, 1, 1'b1, -1, -1);
    send_frame(16'h0002, 1, 1'b0, -1, -1);
    send_frame(16'h0040, 2, 1'b0, 2, -1);
    send_frame(16'h0080, 1, 1'b0, -1, -1);
    send_frame(16'h0100, 2, 1'b0, -1, 3);
    send_frame(16'h0200, 2, 1'b0, -1, -1);
    send_frame(16'h0300, 3, 1'b0, -1, 7);
    send_frame(16'hFFFC, 1, 1'b0, -1, -1);
    send_frame(16'h0400, 0, 1'b0, -1, -1);
    send_frame(16'h0500, 2, 1'b0, 6, -1);

    for (int r = 0; r < 25; r++) begin
      b = 16'($urandom);
      if ($urandom_range(0, 4) != 0) b[1:0] = 2'b00;
      send_frame(b, $urandom_range(1, 4),
                 ($urandom_range(0, 3) == 0), -1, -1);
    end

    repeat (5) @(negedge clk);
    chk("writes_left", 64'(wexp.size()), 64'd0);
    chk("outcomes_left", 64'(oexp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
